// File: rtl/reg_file_sweep_pkg.sv
// rtl/reg_file_sweep_pkg.sv - shared CPU width constants, timing constants and sweep state type
`timescale 1ns/100ps

package cpu_pkg;

  // Datapath widths shared with the ALU and two's-complement unit
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  // Nominal settle times (ns) for read data and committed writes
  localparam int RD_DLY = 2;
  localparam int WR_DLY = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/reg_file_sweep_if.sv
// rtl/reg_file_sweep_if.sv - register file write/read/clear bus with control-unit and register-file views
`timescale 1ns/100ps

interface reg_file_sweep_if;
  import cpu_pkg::*;

  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic              CLEAR_REQ;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              BUSY;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR_REQ,
    input  OUT1, OUT2, BUSY
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, CLEAR_REQ,
    output OUT1, OUT2, BUSY
  );

endinterface

// File: rtl/reg_file_sweep_fsm.sv
// rtl/reg_file_sweep_fsm.sv - sweep-clear sequencer: state, pointer, BUSY and per-register clear strobe
`timescale 1ns/100ps

module regfile_sweep_fsm
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clear_req,
  output logic              busy,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  sweep_state_t      state;
  logic [ADDR_W-1:0] ptr;

  // Sequence IDLE -> SWEEP on a clear request, one register per cycle, back to IDLE after the last
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          // Pointer wraps naturally to 0 on the exit edge; requests here are ignored
          ptr <= ptr + 1'b1;
          if (ptr == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_stb = (state == ST_SWEEP);
  assign clr_idx = ptr;

endmodule

// File: rtl/reg_file_sweep.sv
// rtl/reg_file_sweep.sv - 8x8 register file, two async read ports, one write port, sweep clear (opt. REGFILE_FWD_EN)
`timescale 1ns/100ps

module reg_file_sweep
  import cpu_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET_N,
  reg_file_sweep_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              busy;
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_idx;

  regfile_sweep_fsm u_fsm (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .clear_req (bus.CLEAR_REQ),
    .busy      (busy),
    .clr_stb   (clr_stb),
    .clr_idx   (clr_idx)
  );

  assign bus.BUSY = busy;

  // Storage: async reset to zero, sweep clears one entry per cycle, writes only land while idle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (clr_stb) begin
      regs[clr_idx] <= '0;
    end else if (bus.WRITE) begin
      regs[bus.INADDRESS] <= bus.IN;
    end
  end

`ifdef REGFILE_FWD_EN
  // A pending idle write is visible on a matching read port before it commits
  logic wr_live;
  assign wr_live  = bus.WRITE && !clr_stb;
  assign bus.OUT1 = (wr_live && (bus.INADDRESS == bus.OUT1ADDRESS)) ? bus.IN : regs[bus.OUT1ADDRESS];
  assign bus.OUT2 = (wr_live && (bus.INADDRESS == bus.OUT2ADDRESS)) ? bus.IN : regs[bus.OUT2ADDRESS];
`else
  assign bus.OUT1 = regs[bus.OUT1ADDRESS];
  assign bus.OUT2 = regs[bus.OUT2ADDRESS];
`endif

endmodule

// File: tb/tb_reg_file_sweep.sv
// tb/tb_reg_file_sweep.sv - directed self-checking bench for reg_file_sweep
`timescale 1ns/100ps

module tb_reg_file_sweep;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   fails;

  reg_file_sweep_if rf ();

  reg_file_sweep dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2,
                    input logic [7:0] e1, input logic [7:0] e2, input string tag);
    rf.OUT1ADDRESS = a1;
    rf.OUT2ADDRESS = a2;
    #RD_DLY;
    chk({tag, ".out1"}, rf.OUT1, e1);
    chk({tag, ".out2"}, rf.OUT2, e2);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    rf.IN        = d;
    rf.INADDRESS = a;
    rf.WRITE     = 1'b1;
    @(posedge clk);
    #WR_DLY;
    rf.WRITE = 1'b0;
  endtask

  task automatic start_clear();
    @(negedge clk);
    rf.CLEAR_REQ = 1'b1;
    @(posedge clk);
    #1;
    rf.CLEAR_REQ = 1'b0;
  endtask

  initial begin
    total = 0;
    fails = 0;
    rst_n = 1'b0;
    rf.IN = '0;
    rf.INADDRESS = '0;
    rf.WRITE = 1'b0;
    rf.OUT1ADDRESS = '0;
    rf.OUT2ADDRESS = '0;
    rf.CLEAR_REQ = 1'b0;
    #12;
    chk("reset.busy", {7'd0, rf.BUSY}, 8'h00);
    rd(3'd0, 3'd7, 8'h00, 8'h00, "reset.read");
    @(negedge clk);
    rst_n = 1'b1;

    // basic write/read
    wr(3'd3, 8'd10);
    wr(3'd5, 8'd12);
    rd(3'd3, 3'd5, 8'd10, 8'd12, "rw.r3r5");

    // async reset in the middle of a cycle
    wr(3'd1, 8'hAA);
    rd(3'd1, 3'd1, 8'hAA, 8'hAA, "rw.r1");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out1", rf.OUT1, 8'h00);
    chk("async_rst.busy", {7'd0, rf.BUSY}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // full load then sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
    rd(3'd0, 3'd7, 8'd1, 8'd8, "load.r0r7");
    start_clear();
    chk("sweep1.busy_e0", {7'd0, rf.BUSY}, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    rd(3'd0, 3'd1, 8'd0, 8'd0, "sweep1.e3_r0r1");
    rd(3'd2, 3'd3, 8'd0, 8'd4, "sweep1.e3_r2r3");
    repeat (4) @(posedge clk);
    #1;
    chk("sweep1.busy_e7", {7'd0, rf.BUSY}, 8'h01);
    @(posedge clk);
    #1;
    chk("sweep1.busy_e8", {7'd0, rf.BUSY}, 8'h00);
    for (int i = 0; i < 4; i++) rd(3'(2 * i), 3'(2 * i + 1), 8'd0, 8'd0, "sweep1.final");

    // write and second clear request during a sweep
    wr(3'd6, 8'h09);
    start_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rf.IN = 8'h55;
    rf.INADDRESS = 3'd6;
    rf.WRITE = 1'b1;
    rf.CLEAR_REQ = 1'b1;
    @(posedge clk);
    #1;
    rf.WRITE = 1'b0;
    rf.CLEAR_REQ = 1'b0;
    rd(3'd6, 3'd6, 8'h09, 8'h09, "sweep2.drop_r6");
    repeat (4) @(posedge clk);
    #1;
    chk("sweep2.busy_e7", {7'd0, rf.BUSY}, 8'h01);
    @(posedge clk);
    #1;
    chk("sweep2.busy_e8", {7'd0, rf.BUSY}, 8'h00);
    rd(3'd6, 3'd6, 8'h00, 8'h00, "sweep2.r6_after");

    // write and clear on the same idle edge
    @(negedge clk);
    rf.IN = 8'h33;
    rf.INADDRESS = 3'd7;
    rf.WRITE = 1'b1;
    rf.CLEAR_REQ = 1'b1;
    @(posedge clk);
    #1;
    rf.WRITE = 1'b0;
    rf.CLEAR_REQ = 1'b0;
    chk("sweep3.busy_e0", {7'd0, rf.BUSY}, 8'h01);
    rd(3'd7, 3'd7, 8'h33, 8'h33, "sweep3.r7_e0");
    repeat (7) @(posedge clk);
    #1;
    rd(3'd7, 3'd7, 8'h33, 8'h33, "sweep3.r7_e7");
    @(posedge clk);
    #1;
    rd(3'd7, 3'd7, 8'h00, 8'h00, "sweep3.r7_e8");
    chk("sweep3.busy_e8", {7'd0, rf.BUSY}, 8'h00);

    // same-cycle read-after-write
    wr(3'd2, 8'h11);
    @(negedge clk);
    rf.IN = 8'h7F;
    rf.INADDRESS = 3'd2;
    rf.WRITE = 1'b1;
    rf.OUT1ADDRESS = 3'd3;
    rf.OUT2ADDRESS = 3'd2;
    #RD_DLY;
`ifdef REGFILE_FWD_EN
    chk("raw.out2_pre", rf.OUT2, 8'h7F);
`else
    chk("raw.out2_pre", rf.OUT2, 8'h11);
`endif
    chk("raw.out1_pre", rf.OUT1, 8'h00);
    @(posedge clk);
    #WR_DLY;
    rf.WRITE = 1'b0;
    #RD_DLY;
    chk("raw.out2_post", rf.OUT2, 8'h7F);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
